// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I pipeline hazard controller: forwarding selects and
// controller state encoding.
package pipeline_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REGW_DEF = 5;
  localparam int unsigned FWD_W    = 2;
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } hzd_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage operand forwarding select for one source operand.
// EX/MEM has priority over MEM/WB; x0 is never forwarded.
module fwd_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REGW = REGW_DEF
) (
  input  logic [REGW-1:0] ex_rs,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_regwrite,
  input  logic            exmem_is_load,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_regwrite,
  output fwd_sel_t        sel
);

  // A load in EX/MEM has no result yet, so it cannot supply the operand.
  always_comb begin
    sel = FWD_RF;
    if (exmem_regwrite && !exmem_is_load && (exmem_rd != '0) && (exmem_rd == ex_rs)) begin
      sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32I pipeline; reconciles
// imem and dmem responses so all stages advance together.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned REGW = REGW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [XLEN-1:0]  if_instr,
  output logic [XLEN-1:0]  mem_rdata,
  input  logic [REGW-1:0]  id_rs1,
  input  logic [REGW-1:0]  id_rs2,
  input  logic [REGW-1:0]  ex_rs1,
  input  logic [REGW-1:0]  ex_rs2,
  input  logic [REGW-1:0]  idex_rd,
  input  logic             idex_is_load,
  input  logic [REGW-1:0]  exmem_rd,
  input  logic [REGW-1:0]  memwb_rd,
  input  logic             exmem_regwrite,
  input  logic             memwb_regwrite,
  input  logic             exmem_is_load,
  input  logic             br_taken,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [FWD_W-1:0] fwd_a_sel,
  output logic [FWD_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_mem_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzd_state_t      state, next_state;
  logic [XLEN-1:0] ibuf, dbuf;
  logic            i_ok, d_ok, advance, load_use;
  logic            ld_ibuf, ld_dbuf;
  fwd_sel_t        fwd_a, fwd_b;

  assign i_ok     = imem_resp | (state == WAIT_D);
  assign d_ok     = !dmem_req | dmem_resp | (state == WAIT_I);
  assign advance  = i_ok & d_ok;
  assign load_use = idex_is_load & (idex_rd != '0) & ((idex_rd == id_rs1) | (idex_rd == id_rs2));

  // Only capture an early word from RUN; the partner side is what we wait on.
  assign ld_ibuf  = (state == RUN) & imem_resp & !advance;
  assign ld_dbuf  = (state == RUN) & dmem_resp & !advance;

  assign if_instr  = (state == WAIT_D) ? ibuf : imem_rdata;
  assign mem_rdata = (state == WAIT_I) ? dbuf : dmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf <= '0;
      dbuf <= '0;
    end else begin
      if (ld_ibuf) ibuf <= imem_rdata;
      if (ld_dbuf) dbuf <= dmem_rdata;
    end
  end

  // Next state plus pipeline enables; a frozen cycle issues no loads or flushes.
  always_comb begin
    next_state = state;
    load_pc    = 1'b0;
    load_ifid  = 1'b0;
    load_idex  = 1'b0;
    load_exmem = 1'b0;
    load_memwb = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    if (advance) begin
      next_state = RUN;
    end else if (ld_ibuf) begin
      next_state = WAIT_D;
    end else if (ld_dbuf) begin
      next_state = WAIT_I;
    end

    if (!rst && advance) begin
      load_pc    = 1'b1;
      load_ifid  = 1'b1;
      load_idex  = 1'b1;
      load_exmem = 1'b1;
      load_memwb = 1'b1;
      if (br_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        load_pc    = 1'b0;
        load_ifid  = 1'b0;
        flush_idex = 1'b1;
      end
    end
  end

  fwd_unit #(.REGW(REGW)) u_fwd_a (
    .ex_rs          (ex_rs1),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_is_load  (exmem_is_load),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .sel            (fwd_a)
  );

  fwd_unit #(.REGW(REGW)) u_fwd_b (
    .ex_rs          (ex_rs2),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_is_load  (exmem_is_load),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .sel            (fwd_b)
  );

  assign fwd_a_sel = rst ? FWD_W'(FWD_RF) : FWD_W'(fwd_a);
  assign fwd_b_sel = rst ? FWD_W'(FWD_RF) : FWD_W'(fwd_b);

`ifdef PIPE_PERF_CNT_EN
  logic bubble_ev, flush_ev;

  assign bubble_ev = advance & load_use & !br_taken;
  assign flush_ev  = advance & br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_mem_cnt <= '0;
      bubble_cnt    <= '0;
      flush_cnt     <= '0;
    end else begin
      if (!advance) stall_mem_cnt <= stall_mem_cnt + CNT_W'(1);
      if (bubble_ev) bubble_cnt   <= bubble_cnt + CNT_W'(1);
      if (flush_ev)  flush_cnt    <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_mem_cnt = '0;
  assign bubble_cnt    = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; counter expectations
// follow whether PIPE_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst;
  logic        imem_resp, dmem_req, dmem_resp;
  logic [31:0] imem_rdata, dmem_rdata, if_instr, mem_rdata;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic        idex_is_load, exmem_regwrite, memwb_regwrite, exmem_is_load, br_taken;
  logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic        flush_ifid, flush_idex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_mem_cnt, bubble_cnt, flush_cnt;
  logic [4:0]  lds;
  logic [1:0]  fls;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .if_instr(if_instr), .mem_rdata(mem_rdata),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .idex_rd(idex_rd), .idex_is_load(idex_is_load),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_is_load(exmem_is_load), .br_taken(br_taken),
    .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_mem_cnt(stall_mem_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  assign lds = {load_pc, load_ifid, load_idex, load_exmem, load_memwb};
  assign fls = {flush_ifid, flush_idex};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] cnt(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  initial begin
    rst = 1'b1;
    imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    imem_rdata = 32'h0; dmem_rdata = 32'h0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd3; ex_rs2 = 5'd0;
    idex_rd = 5'd0; idex_is_load = 1'b0;
    exmem_rd = 5'd3; memwb_rd = 5'd0;
    exmem_regwrite = 1'b1; memwb_regwrite = 1'b0; exmem_is_load = 1'b0;
    br_taken = 1'b1;
    step(); step();

    // Reset values while rst is held, with conditions that would otherwise act
    check("rst_loads", 32'(lds), 32'h0);
    check("rst_flush", 32'(fls), 32'h0);
    check("rst_fwd_a", 32'(fwd_a_sel), 32'h0);
    check("rst_stall_cnt", stall_mem_cnt, 32'h0);
    check("rst_bubble_cnt", bubble_cnt, 32'h0);
    check("rst_flush_cnt", flush_cnt, 32'h0);

    rst = 1'b0; br_taken = 1'b0; exmem_regwrite = 1'b0; ex_rs1 = 5'd0; exmem_rd = 5'd0;
    step();

    // 1: simultaneous responses, no hazards
    imem_resp = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'h00000013 + 32'(i << 8);
      dmem_rdata = 32'h10000000 + 32'(i);
      settle();
      check("t1_loads", 32'(lds), 32'h1f);
      check("t1_if_instr", if_instr, 32'h00000013 + 32'(i << 8));
      check("t1_mem_rdata", mem_rdata, 32'h10000000 + 32'(i));
      step();
    end
    check("t1_fwd_a", 32'(fwd_a_sel), 32'h0);
    check("t1_stall_cnt", stall_mem_cnt, 32'h0);

    // 2: imem early at cycle 0, dmem at cycle 3
    imem_resp = 1'b1; imem_rdata = 32'h00500093; dmem_resp = 1'b0; dmem_rdata = 32'h0BAD0000;
    settle();
    check("t2_c0_loads", 32'(lds), 32'h0);
    step();
    for (int c = 1; c < 3; c++) begin
      imem_resp = 1'b0; imem_rdata = 32'h11111111 * 32'(c);
      settle();
      check("t2_stall_loads", 32'(lds), 32'h0);
      check("t2_ibuf_hold", if_instr, 32'h00500093);
      step();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF;
    settle();
    check("t2_c3_loads", 32'(lds), 32'h1f);
    check("t2_c3_if_instr", if_instr, 32'h00500093);
    check("t2_c3_mem_rdata", mem_rdata, 32'hDEADBEEF);
    step();
    check("t2_stall_cnt", stall_mem_cnt, cnt(3));
    imem_resp = 1'b1; imem_rdata = 32'h22222222;
    settle();
    check("t2_back_to_run", if_instr, 32'h22222222);
    step();

    // dmem early: buffered in WAIT_I, released when imem arrives
    imem_resp = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D;
    settle();
    check("wi_loads", 32'(lds), 32'h0);
    step();
    imem_resp = 1'b1; dmem_resp = 1'b0; dmem_rdata = 32'h0;
    settle();
    check("wi_release_loads", 32'(lds), 32'h1f);
    check("wi_mem_rdata", mem_rdata, 32'hCAFEF00D);
    step();
    check("wi_stall_cnt", stall_mem_cnt, cnt(4));
    dmem_req = 1'b0;

    // 3: load-use hazard inserts one bubble
    idex_is_load = 1'b1; idex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd0;
    settle();
    check("t3_loads", 32'(lds), 32'h07);
    check("t3_flush", 32'(fls), 32'h1);
    step();
    idex_is_load = 1'b0;
    settle();
    check("t3_next_loads", 32'(lds), 32'h1f);
    check("t3_next_flush", 32'(fls), 32'h0);
    check("t3_bubble_cnt", bubble_cnt, cnt(1));
    idex_is_load = 1'b1; idex_rd = 5'd0; id_rs2 = 5'd0;
    settle();
    check("t3_x0_no_hazard", 32'(lds), 32'h1f);
    idex_rd = 5'd5; id_rs2 = 5'd5; imem_resp = 1'b0;
    settle();
    check("t3_frozen_loads", 32'(lds), 32'h0);
    check("t3_frozen_flush", 32'(fls), 32'h0);
    step();

    // 4: branch overrides load-use
    imem_resp = 1'b1; br_taken = 1'b1;
    settle();
    check("t4_loads", 32'(lds), 32'h1f);
    check("t4_flush", 32'(fls), 32'h3);
    step();
    check("t4_bubble_cnt", bubble_cnt, cnt(1));
    check("t4_flush_cnt", flush_cnt, cnt(1));
    imem_resp = 1'b0;
    settle();
    check("t4_frozen_flush", 32'(fls), 32'h0);
    step();
    check("t4_frozen_flush_cnt", flush_cnt, cnt(1));
    check("t4_stall_cnt", stall_mem_cnt, cnt(6));
    br_taken = 1'b0; idex_is_load = 1'b0; imem_resp = 1'b1;

    // 5: forwarding priority and x0
    exmem_rd = 5'd7; memwb_rd = 5'd7; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1; ex_rs1 = 5'd7;
    settle();
    check("t5_fwd_exmem", 32'(fwd_a_sel), 32'h1);
    exmem_is_load = 1'b1;
    settle();
    check("t5_fwd_load_memwb", 32'(fwd_a_sel), 32'h2);
    exmem_is_load = 1'b0; exmem_rd = 5'd0; memwb_rd = 5'd0; ex_rs1 = 5'd0;
    settle();
    check("t5_fwd_x0", 32'(fwd_a_sel), 32'h0);
    exmem_rd = 5'd9; memwb_rd = 5'd4; ex_rs2 = 5'd4;
    settle();
    check("t5_fwd_b_memwb", 32'(fwd_b_sel), 32'h2);
    memwb_regwrite = 1'b0;
    settle();
    check("t5_fwd_b_nowrite", 32'(fwd_b_sel), 32'h0);
    exmem_regwrite = 1'b0;
    step();

    // 6: reset while waiting in WAIT_D drops the buffered instruction
    imem_resp = 1'b1; imem_rdata = 32'hAAAA5555; dmem_req = 1'b1; dmem_resp = 1'b0;
    step();
    imem_resp = 1'b0; imem_rdata = 32'h12345678;
    settle();
    check("t6_wd_if_instr", if_instr, 32'hAAAA5555);
    check("t6_pre_stall_cnt", stall_mem_cnt, cnt(7));
    rst = 1'b1;
    settle();
    check("t6_rst_loads", 32'(lds), 32'h0);
    step();
    rst = 1'b0; dmem_resp = 1'b1;
    settle();
    check("t6_run_loads", 32'(lds), 32'h0);
    check("t6_if_instr_live", if_instr, 32'h12345678);
    check("t6_stall_cnt", stall_mem_cnt, 32'h0);
    check("t6_flush_cnt", flush_cnt, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall, flush and forwarding controller for the 5-stage RV32I pipeline. It drives the load and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC, and it selects the EX-stage forwarding sources. It reconciles imem and dmem responses that arrive in different cycles, holding whichever data word arrived early, so that the whole pipeline advances in lockstep.

Parameters:
XLEN, 32, data/instruction word width
REGW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
imem_resp  in  1  instruction fetch complete this cycle
imem_rdata  in  XLEN  fetched instruction
dmem_req  in  1  MEM stage holds a load or store (EX/MEM dmem_read|dmem_write)
dmem_resp  in  1  data access complete this cycle
dmem_rdata  in  XLEN  load data
if_instr  out  XLEN  instruction presented to IF/ID input
mem_rdata  out  XLEN  load data presented to MEM/WB input
id_rs1, id_rs2  in  REGW  source registers of instruction in ID
ex_rs1, ex_rs2  in  REGW  source registers of instruction in EX
idex_rd  in  REGW  destination register in ID/EX
idex_is_load  in  1  ID/EX holds a load
exmem_rd, memwb_rd  in  REGW  destination registers
exmem_regwrite, memwb_regwrite  in  1  destination writes regfile
exmem_is_load  in  1  EX/MEM holds a load
br_taken  in  1  EX resolved a taken branch or jump
load_pc, load_ifid, load_idex, load_exmem, load_memwb  out  1  register enables
flush_ifid, flush_idex  out  1  replace register contents with a NOP bubble on load
fwd_a_sel, fwd_b_sel  out  2  0=regfile, 1=EX/MEM ALU result, 2=MEM/WB writeback value
stall_mem_cnt, bubble_cnt, flush_cnt  out  32  performance counters

Behaviour:
- FSM states: RUN, WAIT_I (dmem done, imem pending), WAIT_D (imem done, dmem pending).
- i_ok = imem_resp | (state==WAIT_D).
- d_ok = !dmem_req | dmem_resp | (state==WAIT_I).
- advance = i_ok & d_ok.
- Early data buffering:
  - On imem_resp without advance: latch imem_rdata into ibuf and go to WAIT_D.
  - On dmem_resp without advance: latch dmem_rdata into dbuf and go to WAIT_I.
  - On advance: return to RUN and clear both flags.
- Data outputs:
  - if_instr = ibuf in WAIT_D, else imem_rdata.
  - mem_rdata = dbuf in WAIT_I, else dmem_rdata.
- Advance and stall:
  - advance=0: all load_* outputs are 0 and flushes are 0, so the pipeline is frozen.
  - advance=1: all load_* outputs are 1, subject to the hazard rules below.
- Load-use hazard: idex_is_load & idex_rd!=0 & (idex_rd==id_rs1 | idex_rd==id_rs2).
  - Response: load_pc=0, load_ifid=0, flush_idex=1. Exactly one bubble is inserted.
- Taken branch: br_taken gives flush_ifid=1 and flush_idex=1, with load_pc=1.
  - Branch has priority over load-use, because the stalled instruction is discarded.
- Flushes and hazard stalls take effect only in cycles where advance=1.
- Forwarding for operand A (B is identical using ex_rs2):
  - Select 1 if exmem_regwrite & !exmem_is_load & exmem_rd!=0 & exmem_rd==ex_rs1.
  - Otherwise select 2 if memwb_regwrite & memwb_rd!=0 & memwb_rd==ex_rs1.
  - Otherwise select 0. EX/MEM wins over MEM/WB.
  - x0 is never forwarded.
- Simultaneous imem_resp and dmem_resp in RUN: advance immediately, nothing is buffered.
- Reset:
  - While rst is asserted: state=RUN, ibuf=dbuf=0, all load_*=0, flush_*=0, fwd_*=0, counters=0.
  - Reset in WAIT_I or WAIT_D drops the buffered word. No response is replayed.
- Counters: 32-bit, wrap modulo 2^32.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_mem_cnt increments each cycle advance=0.
  - bubble_cnt increments on each inserted load-use bubble.
  - flush_cnt increments on each taken-branch flush.
- Undefined: all three counters are tied to 0 and no counter flops exist.

Decomposition:
- pipeline_pkg gets:
  - fwd_sel_t enum: FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - hzd_state_t enum: RUN, WAIT_I, WAIT_D.
- One sub-module, fwd_unit: purely combinational operand forwarding, instantiated once per operand.
- The FSM, buffers and stall logic stay in the top module.

Test Plan:
1. Both responses in the same cycle, no hazards -> all load_*=1 every cycle, fwd_*=0, state remains RUN.
2. imem_resp with rdata=0x00500093 at cycle 0, dmem_resp at cycle 3 with rdata=0xDEADBEEF -> loads=0 for cycles 0-2; at cycle 3 loads=1, if_instr=0x00500093, mem_rdata=0xDEADBEEF; stall_mem_cnt=3.
3. idex_is_load=1, idex_rd=5, id_rs2=5 -> one cycle with load_pc=0, load_ifid=0, flush_idex=1; the next cycle is normal; bubble_cnt=1.
4. Same load-use condition plus br_taken=1 -> flush_ifid=1, flush_idex=1, load_pc=1, bubble_cnt unchanged, flush_cnt=1.
5. exmem_rd=memwb_rd=7, both regwrite, ex_rs1=7 -> fwd_a_sel=1; with exmem_is_load=1 -> fwd_a_sel=2; with rd=0 -> fwd_a_sel=0.
6. rst asserted in WAIT_D -> next cycle state=RUN, if_instr follows live imem_rdata, all outputs at reset values.
